// File: rtl/ft601_pkg.sv
// Shared types and constants for the FT601 TX path: FSM states, header layout and
// the header packing helper.
package ft601_pkg;

    localparam int NUM_PERIPH_DEF = 8;
    localparam int GRANT_W        = $clog2(NUM_PERIPH_DEF);
    localparam int LEN_W          = 8;

    localparam logic [7:0] HDR_SYNC  = 8'hA5;
    localparam int HDR_SYNC_LSB      = 24;
    localparam int HDR_ID_LSB        = 16;
    localparam int HDR_LEN_LSB       = 0;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BURST,
        DONE
    } tx_state_t;

    // Header word: {sync, 5'b0, id, 8'b0, len}
    function automatic logic [31:0] make_header(input logic [GRANT_W-1:0] id,
                                                input logic [LEN_W-1:0]   len);
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 8]      = HDR_SYNC;
        hdr[HDR_ID_LSB   +: GRANT_W] = id;
        hdr[HDR_LEN_LSB  +: LEN_W]   = len;
        return hdr;
    endfunction

endpackage

// File: rtl/ft601_tx_mux.sv
// Picks one W-bit field out of a packed per-peripheral bus (peripheral 0 in the LSBs).
module ft601_tx_mux #(
    parameter int NUM_PERIPH = 8,
    parameter int W          = 32,
    parameter int SEL_W      = $clog2(NUM_PERIPH)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_PERIPH*W-1:0] bus,
    output logic [W-1:0]            out
);

    always_comb begin
        out = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (sel == SEL_W'(i)) out = bus[i*W +: W];
        end
    end

endmodule

// File: rtl/ft601_tx_sequencer.sv
// Drains the granted RX FIFO into the FT601 as one burst and pulses read_periph_data at the end.
// Define FT601_TX_HEADER_EN to prefix every burst with the 32-bit id/len header word.
module ft601_tx_sequencer
    import ft601_pkg::*;
#(
    parameter int NUM_PERIPH = NUM_PERIPH_DEF,
    parameter int DATA_W     = 32,
    parameter int LVL_W      = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [GRANT_W-1:0]           grant,
    output logic                         read_periph_data,
    input  logic [NUM_PERIPH-1:0]        rx_fifo_empty,
    input  logic [NUM_PERIPH*LVL_W-1:0]  rx_fifo_level,
    input  logic [NUM_PERIPH*DATA_W-1:0] rx_fifo_dout,
    output logic [NUM_PERIPH-1:0]        rx_fifo_rd_en,
    input  logic                         ft_txe_n,
    output logic                         ft_wr_n,
    output logic [3:0]                   ft_be,
    output logic [DATA_W-1:0]            ft_data_out,
    output logic                         ft_data_oe
);

    localparam logic [LVL_W-1:0] MAX_LVL = LVL_W'(MAX_BURST);

    tx_state_t          state_q, state_d;
    logic [GRANT_W-1:0] id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]   grant_level;
    logic [DATA_W-1:0]  id_dout;
    logic               xfer;

    // Empty flags are informational only; the fill level decides whether a burst starts.
    logic unused_empty;
    assign unused_empty = ^rx_fifo_empty;

    ft601_tx_mux #(.NUM_PERIPH(NUM_PERIPH), .W(LVL_W), .SEL_W(GRANT_W)) u_grant_mux (
        .sel (grant),
        .bus (rx_fifo_level),
        .out (grant_level)
    );

    ft601_tx_mux #(.NUM_PERIPH(NUM_PERIPH), .W(DATA_W), .SEL_W(GRANT_W)) u_id_mux (
        .sel (id_q),
        .bus (rx_fifo_dout),
        .out (id_dout)
    );

    // Reset gates the strobe so no word is popped in the cycle reset is applied.
    assign xfer = ((state_q == HEADER) || (state_q == BURST)) && !ft_txe_n && !rst;

    always_comb begin
        // NOTE: every _d signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (grant_level != '0) begin
                    id_d  = grant;
                    len_d = LEN_W'((grant_level > MAX_LVL) ? MAX_LVL : grant_level);
                    cnt_d = '0;
`ifdef FT601_TX_HEADER_EN
                    state_d = HEADER;
`else
                    state_d = BURST;
`endif
                end
            end
`ifdef FT601_TX_HEADER_EN
            HEADER: if (xfer) state_d = BURST;
`endif
            BURST: begin
                if (xfer) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_d == len_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ft_data_oe       = (state_q == HEADER) || (state_q == BURST);
        ft_be            = ft_data_oe ? 4'hF : 4'h0;
        ft_wr_n          = !xfer;
        read_periph_data = (state_q == DONE);
        rx_fifo_rd_en    = '0;
        if ((state_q == BURST) && xfer) rx_fifo_rd_en[id_q] = 1'b1;
        ft_data_out = '0;
        case (state_q)
`ifdef FT601_TX_HEADER_EN
            HEADER:  ft_data_out = DATA_W'(make_header(id_q, len_q));
`endif
            BURST:   ft_data_out = id_dout;
            default: ft_data_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples the _d values from before this edge.
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ft601_tx_sequencer.sv
// Self-checking bench: queue-based FIFO models, a stream scoreboard, a vector table,
// hand-written corner sequences and randomized bursts.
module tb_ft601_tx_sequencer;

    localparam int NP   = 8;
    localparam int DW   = 32;
    localparam int LW   = 8;
    localparam int MAXB = 16;
`ifdef FT601_TX_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       grant;
    logic             read_periph_data;
    logic [NP-1:0]    rx_fifo_empty;
    logic [NP*LW-1:0] rx_fifo_level;
    logic [NP*DW-1:0] rx_fifo_dout;
    logic [NP-1:0]    rx_fifo_rd_en;
    logic             ft_txe_n;
    logic             ft_wr_n;
    logic [3:0]       ft_be;
    logic [DW-1:0]    ft_data_out;
    logic             ft_data_oe;

    always #5 clk = ~clk;

    ft601_tx_sequencer #(.NUM_PERIPH(NP), .DATA_W(DW), .LVL_W(LW), .MAX_BURST(MAXB)) dut (
        .clk              (clk),
        .rst              (rst),
        .grant            (grant),
        .read_periph_data (read_periph_data),
        .rx_fifo_empty    (rx_fifo_empty),
        .rx_fifo_level    (rx_fifo_level),
        .rx_fifo_dout     (rx_fifo_dout),
        .rx_fifo_rd_en    (rx_fifo_rd_en),
        .ft_txe_n         (ft_txe_n),
        .ft_wr_n          (ft_wr_n),
        .ft_be            (ft_be),
        .ft_data_out      (ft_data_out),
        .ft_data_oe       (ft_data_oe)
    );

    typedef struct {
        int          p;
        int          n;
        int          s_after;
        int          s_len;
        logic [31:0] hdr;
        int          pops;
        int          cycles;
        int          left;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo_q [NP][$];
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          rpd_cyc[$];
    int          payload_n, rpd_n, cyc, exp_p, next_p;
    logic        prev_rpd;
    logic [NP-1:0] last_rd;
    logic        last_wr_n, last_oe, last_rpd;
    logic [3:0]  last_be;
    logic [31:0] last_data;
    vec_t        vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            rx_fifo_level[i*LW +: LW] = (fifo_q[i].size() > 255) ? 8'hFF : 8'(fifo_q[i].size());
            rx_fifo_dout[i*DW +: DW]  = (fifo_q[i].size() != 0) ? fifo_q[i][0] : 32'h0;
            rx_fifo_empty[i]          = (fifo_q[i].size() == 0);
        end
    endtask

    task automatic load(input int p, input int n);
        for (int i = 0; i < n; i++) fifo_q[p].push_back($urandom);
        refresh();
    endtask

    task automatic flush(input int p);
        fifo_q[p].delete();
        refresh();
    endtask

    task automatic start_test();
        got.delete();
        exp_q.delete();
        rpd_cyc.delete();
        payload_n = 0;
        rpd_n     = 0;
        next_p    = -1;
    endtask

    // Reference model: header (when enabled) then the first min(level, MAX_BURST) words.
    task automatic expect_burst(input int p);
        int len;
        len = (fifo_q[p].size() < MAXB) ? fifo_q[p].size() : MAXB;
        if (HDR != 0) exp_q.push_back({8'hA5, 5'b0, 3'(p), 8'b0, 8'(len)});
        for (int i = 0; i < len; i++) exp_q.push_back(fifo_q[p][i]);
    endtask

    // One clock: sample outputs on the falling edge, then let the FIFO models pop after the rising edge.
    task automatic tick();
        logic [NP-1:0] rd;
        @(negedge clk);
        rd        = rx_fifo_rd_en;
        last_rd   = rd;
        last_wr_n = ft_wr_n;
        last_be   = ft_be;
        last_data = ft_data_out;
        last_oe   = ft_data_oe;
        last_rpd  = read_periph_data;
        check("be_follows_oe", 32'(ft_be), ft_data_oe ? 32'hF : 32'h0);
        if (rd != '0) check("rd_en_target", 32'(rd), 32'(1) << exp_p);
        if (ft_txe_n) begin
            check("stall_wr_n", 32'(ft_wr_n), 32'd1);
            check("stall_no_pop", 32'(rd), 32'd0);
            if (ft_data_oe && got.size() < exp_q.size())
                check("stall_hold", ft_data_out, exp_q[got.size()]);
        end
        if (!ft_wr_n) got.push_back(ft_data_out);
        if (read_periph_data) begin
            check("rpd_one_cycle", 32'(prev_rpd), 32'd0);
            rpd_n++;
            rpd_cyc.push_back(cyc);
            if (next_p >= 0) begin
                exp_p  = next_p;
                next_p = -1;
            end
        end
        prev_rpd = read_periph_data;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd[i]) begin
                if (fifo_q[i].size() > 0) void'(fifo_q[i].pop_front());
                payload_n++;
            end
        end
        refresh();
        cyc++;
    endtask

    // Run until the given number of burst-end pulses, with one optional ft_txe_n stall window.
    task automatic run(input int pulses, input int budget, input int s_after, input int s_len,
                       output int cycles);
        int left;
        bit done;
        left   = 0;
        done   = (s_len == 0);
        cycles = 0;
        while (rpd_n < pulses && cycles < budget) begin
            tick();
            cycles++;
            if (left > 0) begin
                left--;
                if (left == 0) ft_txe_n = 1'b0;
            end else if (!done && payload_n == s_after) begin
                ft_txe_n = 1'b1;
                left     = s_len;
                done     = 1'b1;
            end
        end
        check("burst_end_seen", 32'(rpd_n), 32'(pulses));
    endtask

    task automatic compare_stream(input string tag);
        check($sformatf("%s_words", tag), 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cycles, p, n, len;
        vec_t v;

        vecs[0] = '{p:3, n:5,  s_after:-1, s_len:0, hdr:32'hA503_0005, pops:5,  cycles:8,  left:0};
        vecs[1] = '{p:0, n:40, s_after:-1, s_len:0, hdr:32'hA500_0010, pops:16, cycles:19, left:24};
        vecs[2] = '{p:4, n:4,  s_after:2,  s_len:3, hdr:32'hA504_0004, pops:4,  cycles:10, left:0};
        vecs[3] = '{p:6, n:1,  s_after:-1, s_len:0, hdr:32'hA506_0001, pops:1,  cycles:4,  left:0};
        vecs[4] = '{p:1, n:16, s_after:-1, s_len:0, hdr:32'hA501_0010, pops:16, cycles:19, left:0};
        vecs[5] = '{p:7, n:17, s_after:5,  s_len:2, hdr:32'hA507_0010, pops:16, cycles:21, left:1};

        rst      = 1'b1;
        ft_txe_n = 1'b0;
        grant    = 3'd0;
        exp_p    = 0;
        prev_rpd = 1'b0;
        cyc      = 0;
        start_test();
        for (int i = 0; i < NP; i++) fifo_q[i].delete();
        refresh();
        tick();
        tick();
        check("reset_wr_n", 32'(last_wr_n), 32'd1);
        check("reset_be", 32'(last_be), 32'd0);
        check("reset_data", last_data, 32'd0);
        check("reset_oe", 32'(last_oe), 32'd0);
        check("reset_rpd", 32'(last_rpd), 32'd0);
        check("reset_rd_en", 32'(last_rd), 32'd0);
        rst = 1'b0;
        tick();

        // Table-driven single bursts.
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            start_test();
            load(v.p, v.n);
            grant = 3'(v.p);
            exp_p = v.p;
            expect_burst(v.p);
            run(1, 200, v.s_after, v.s_len, cycles);
            compare_stream($sformatf("vec%0d", k));
            check($sformatf("vec%0d_first", k), (got.size() > 0) ? got[0] : 32'hDEAD_BEEF,
                  (HDR != 0) ? v.hdr : exp_q[0]);
            check($sformatf("vec%0d_pops", k), 32'(payload_n), 32'(v.pops));
            check($sformatf("vec%0d_cycles", k), 32'(cycles), 32'(v.cycles - 1 + HDR));
            check($sformatf("vec%0d_left", k), 32'(fifo_q[v.p].size()), 32'(v.left));
            flush(v.p);
        end

        // Grant moves 5 -> 2 mid-burst: FIFO 5 finishes, then peripheral 2 gets its own burst.
        start_test();
        load(5, 4);
        load(2, 3);
        grant  = 3'd5;
        exp_p  = 5;
        next_p = 2;
        expect_burst(5);
        expect_burst(2);
        cycles = 0;
        while (payload_n < 1 && cycles < 50) begin
            tick();
            cycles++;
        end
        grant = 3'd2;
        run(2, 200, -1, 0, cycles);
        compare_stream("grant_chg");
        check("grant_chg_gap", (rpd_cyc.size() == 2) ? 32'(rpd_cyc[1] - rpd_cyc[0]) : 32'hFFFF_FFFF,
              32'(5 + HDR));
        check("grant_chg_fifo5_left", 32'(fifo_q[5].size()), 32'd0);
        check("grant_chg_fifo2_left", 32'(fifo_q[2].size()), 32'd0);

        // Reset after the first payload word of four.
        start_test();
        load(4, 4);
        grant = 3'd4;
        exp_p = 4;
        cycles = 0;
        while (payload_n < 1 && cycles < 50) begin
            tick();
            cycles++;
        end
        rst = 1'b1;
        tick();
        check("rst_cycle_no_pop", 32'(last_rd), 32'd0);
        rst   = 1'b0;
        grant = 3'd1;
        tick();
        check("post_rst_wr_n", 32'(last_wr_n), 32'd1);
        check("post_rst_be", 32'(last_be), 32'd0);
        check("post_rst_data", last_data, 32'd0);
        check("post_rst_oe", 32'(last_oe), 32'd0);
        check("post_rst_rpd", 32'(last_rpd), 32'd0);
        check("post_rst_rd_en", 32'(last_rd), 32'd0);
        check("post_rst_fifo_left", 32'(fifo_q[4].size()), 32'd3);
        flush(4);

        // Granted FIFO empty for 20 cycles while another holds data: nothing may happen.
        start_test();
        load(4, 3);
        grant = 3'd1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_wr_n_c%0d", c), 32'(last_wr_n), 32'd1);
            check($sformatf("idle_rpd_c%0d", c), 32'(last_rpd), 32'd0);
        end
        check("idle_fifo4_untouched", 32'(fifo_q[4].size()), 32'd3);
        flush(4);

        // Randomized bursts with random back-pressure and grant noise.
        for (int k = 0; k < 25; k++) begin
            p = int'($urandom_range(0, NP - 1));
            n = int'($urandom_range(1, 40));
            start_test();
            load(p, n);
            grant = 3'(p);
            exp_p = p;
            expect_burst(p);
            len = (n < MAXB) ? n : MAXB;
            cycles = 0;
            while (rpd_n < 1 && cycles < 400) begin
                ft_txe_n = ($urandom_range(0, 4) == 0);
                if (cycles > 0) grant = 3'($urandom_range(0, NP - 1));
                tick();
                cycles++;
            end
            ft_txe_n = 1'b0;
            check($sformatf("rnd%0d_done", k), 32'(rpd_n), 32'd1);
            compare_stream($sformatf("rnd%0d", k));
            check($sformatf("rnd%0d_pops", k), 32'(payload_n), 32'(len));
            check($sformatf("rnd%0d_left", k), 32'(fifo_q[p].size()), 32'(n - len));
            flush(p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
